key_schedule_ctrl: RTL and testbench
====================================

Name: key_schedule_ctrl

Overview:
Sequential controller that builds the full AES round-key schedule from one cipher key. It iterates a single shared combinational expansion step (Key_Expansion_new, instantiated at the top level) once per cycle instead of unrolling ten to fourteen copies. Each 128-bit round key is stored in an internal round-key buffer. The cipher and decipher round engines read round keys from this buffer through a registered read port.

Parameters:
KEY_W, 256, width of the cipher-key and expansion-state bus
RK_W, 128, width of one round key
MAX_RK, 15, round-key buffer depth (Nr max 14, plus 1)

Ports:
clk  in  1  system clock; all logic on the rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request to expand key/alg; accepted only in IDLE
key  in  256  cipher key, MSB-aligned (AES-128 uses [255:128])
alg  in  2  00=AES-128 (Nr=10), 01=AES-192 (Nr=12), 10=AES-256 (Nr=14), 11=illegal
busy  out  1  high in EXPAND
done  out  1  one-cycle pulse when the schedule is complete
keys_valid  out  1  level; buffer holds a complete schedule for latched alg
err  out  1  one-cycle pulse: start with alg=11
exp_key_in  out  256  state presented to the shared expansion step
exp_round  out  4  round/rcon index presented to the step
exp_alg  out  2  latched alg presented to the step
exp_key_out  in  256  combinational next state returned by the step
rd_idx  in  4  round-key index to read
rd_key  out  128  registered round key
rd_err  out  1  registered; rd_idx > Nr, or keys_valid low

Behaviour:
- Reset values: all outputs 0; state=IDLE; step=0; cur=0. Buffer contents are not cleared, but keys_valid=0 masks reads.
- States: IDLE, EXPAND.
- IDLE, start=1, alg!=11:
  - cur<=key; alg_q<=alg; rk[0]<=key[255:128]; step<=1
  - keys_valid<=0; busy<=1; go to EXPAND
- IDLE, start=1, alg=11: err<=1 for one cycle; remain IDLE; keys_valid and buffer unchanged.
- EXPAND, every cycle:
  - exp_key_in=cur, exp_round=step, exp_alg=alg_q
  - cur<=exp_key_out; rk[step]<=exp_key_out[255:128]; step<=step+1
- EXPAND with step==Nr(alg_q): the final write occurs, and on the same edge busy<=0, done<=1, keys_valid<=1, state<=IDLE.
- Latency: if start is sampled at edge 0, round key r is written at edge r. done and keys_valid are visible after edge Nr, i.e. 10, 12 or 14 cycles. A new start is accepted in the cycle after done.
- Outside EXPAND, exp_key_in=0 and exp_round=0.
- start while busy: ignored, with no queuing and no error.
- The step counter is 4 bits and never exceeds 14. Nr is derived from alg_q only, so a change on alg mid-run has no effect.
- Read port, one-cycle latency: on each edge, rd_key<=rk[rd_idx] and rd_err<=0 if keys_valid=1 and rd_idx<=Nr. Otherwise rd_key<=0 and rd_err<=1.
  - Reads during EXPAND therefore return 0 with rd_err=1.
  - A read at the done edge returns 0; the first valid read data appears one cycle later.
- Reset mid-EXPAND: next cycle is IDLE with busy=0 and keys_valid=0; no done pulse.
- Reset has priority over start in the same cycle.

Test Plan:
(Bench binds exp_* ports to a Key_Expansion_new model.)
1. AES-128, key=2b7e151628aed2a6abf7158809cf4f3c followed by 128'h0, start 1 cycle -> busy for 10 cycles, done pulse after edge 10. rd_idx=1 gives a0fafe1788542cb123a339392a6c7605. rd_idx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6. rd_idx=11 gives 0 with rd_err=1.
2. AES-256, FIPS-197 key 603deb10...0914dff4, alg=10 -> done after exactly 14 cycles. rd_idx=14 matches the reference model's rk[14]. rd_idx=15 gives rd_err=1.
3. alg=11 with start in IDLE -> err one cycle, busy stays 0, previous keys_valid=1 and its contents unchanged.
4. start re-asserted at cycle 5 of an AES-128 run with a different key -> ignored; the final schedule matches the first key. A start 1 cycle after done is accepted and drops keys_valid.
5. reset asserted at cycle 6 of an AES-192 run -> busy=0, keys_valid=0, no done. Any rd_idx gives 0 with rd_err=1. A following clean run completes in 12 cycles.
6. Read during EXPAND at rd_idx=0 -> rd_key=0 with rd_err=1. The same read issued the cycle after done gives key[255:128] on the next cycle.

Source files
------------

// File: rtl/key_schedule_ctrl.sv
// Iterative AES key-schedule controller: drives one shared expansion step per cycle
// and keeps every round key in a buffer behind a registered read port.
module key_schedule_ctrl #(
  parameter int KEY_W  = 256,
  parameter int RK_W   = 128,
  parameter int MAX_RK = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [KEY_W-1:0] key,
  input  logic [1:0]       alg,
  output logic             busy,
  output logic             done,
  output logic             keys_valid,
  output logic             err,
  output logic [KEY_W-1:0] exp_key_in,
  output logic [3:0]       exp_round,
  output logic [1:0]       exp_alg,
  input  logic [KEY_W-1:0] exp_key_out,
  input  logic [3:0]       rd_idx,
  output logic [RK_W-1:0]  rd_key,
  output logic             rd_err
);

  typedef enum logic {IDLE, EXPAND} state_t;

  state_t           state;
  logic [3:0]       step;
  logic [KEY_W-1:0] cur;
  logic [1:0]       alg_q;
  logic [3:0]       nr;
  logic             accept;
  logic [RK_W-1:0]  rk [MAX_RK];

  // Number of rounds follows the latched algorithm only.
  always_comb begin
    nr = 4'd10;
    case (alg_q)
      2'b00:   nr = 4'd10;
      2'b01:   nr = 4'd12;
      2'b10:   nr = 4'd14;
      default: nr = 4'd10;
    endcase
  end

  // Request handshake: start is a level sampled at each edge; it is taken only in
  // IDLE with a legal alg, is dropped silently while busy, and never queues.
  assign accept = (state == IDLE) && start && (alg != 2'b11);

  assign exp_key_in = (state == EXPAND) ? cur : '0;
  assign exp_round  = (state == EXPAND) ? step : 4'd0;
  assign exp_alg    = alg_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      step       <= 4'd0;
      cur        <= '0;
      alg_q      <= 2'b00;
      busy       <= 1'b0;
      done       <= 1'b0;
      keys_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (alg == 2'b11) begin
              err <= 1'b1;
            end else begin
              cur        <= key;
              alg_q      <= alg;
              step       <= 4'd1;
              keys_valid <= 1'b0;
              busy       <= 1'b1;
              state      <= EXPAND;
            end
          end
        end
        EXPAND: begin
          cur <= exp_key_out;
          if (step == nr) begin
            busy       <= 1'b0;
            done       <= 1'b1;
            keys_valid <= 1'b1;
            step       <= 4'd0;
            state      <= IDLE;
          end else begin
            step <= step + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Buffer is never cleared; keys_valid gates every read instead.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (accept) begin
        rk[0] <= key[KEY_W-1 -: RK_W];
      end else if (state == EXPAND) begin
        rk[step] <= exp_key_out[KEY_W-1 -: RK_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_key <= '0;
      rd_err <= 1'b0;
    end else if (keys_valid && (rd_idx <= nr)) begin
      rd_key <= rk[rd_idx];
      rd_err <= 1'b0;
    end else begin
      rd_key <= '0;
      rd_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Directed bench for key_schedule_ctrl with a behavioural AES expansion step on
// the exp_* ports and FIPS-197 round keys as expected values.
module tb_key_schedule_ctrl;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [255:0] K128 = 256'h2b7e151628aed2a6abf7158809cf4f3c_00000000000000000000000000000000;
  localparam logic [255:0] K192 = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b_0000000000000000;
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [255:0] key = '0;
  logic [1:0]   alg = 2'b00;
  logic         busy, done, keys_valid, err;
  logic [255:0] exp_key_in, exp_key_out;
  logic [3:0]   exp_round;
  logic [1:0]   exp_alg;
  logic [3:0]   rd_idx = 4'd0;
  logic [127:0] rd_key;
  logic         rd_err;

  int total = 0;
  int bad = 0;

  key_schedule_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .key(key), .alg(alg),
    .busy(busy), .done(done), .keys_valid(keys_valid), .err(err),
    .exp_key_in(exp_key_in), .exp_round(exp_round), .exp_alg(exp_alg),
    .exp_key_out(exp_key_out), .rd_idx(rd_idx), .rd_key(rd_key), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input int n);
    logic [7:0] r;
    r = 8'h01;
    for (int m = 1; m < n; m++) r = {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    return r;
  endfunction

  // State is a window of Nk words w[4s..4s+Nk-1], top-aligned; one step slides it by four words.
  function automatic logic [255:0] exp_step(input logic [255:0] st, input logic [3:0] rnd,
                                            input logic [1:0] a);
    logic [31:0]  w [12];
    logic [31:0]  t;
    logic [255:0] o;
    int nk, s, i;
    o = '0;
    for (int j = 0; j < 12; j++) w[j] = '0;
    if (rnd == 4'd0) return o;
    nk = (a == 2'd0) ? 4 : (a == 2'd1) ? 6 : 8;
    s = int'(rnd) - 1;
    for (int j = 0; j < nk; j++) w[j] = st[255 - 32*j -: 32];
    for (int k = 0; k < 4; k++) begin
      i = 4*s + nk + k;
      t = w[nk + k - 1];
      if (i % nk == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rcon(i / nk), 24'h0};
      else if (nk == 8 && i % nk == 4) t = sub_word(t);
      w[nk + k] = w[k] ^ t;
    end
    for (int j = 0; j < nk; j++) o[255 - 32*j -: 32] = w[4 + j];
    return o;
  endfunction

  assign exp_key_out = exp_step(exp_key_in, exp_round, exp_alg);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic start_run(input logic [255:0] k, input logic [1:0] a);
    key = k;
    alg = a;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick;
      n++;
    end
  endtask

  task automatic read(input logic [3:0] idx);
    rd_idx = idx;
    tick;
  endtask

  int n;
  int done_seen;

  initial begin
    tick;
    tick;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_kv", keys_valid, 0);
    check("rst_err", err, 0);
    check("rst_rd_key", rd_key, 0);
    check("rst_rd_err", rd_err, 0);
    check("rst_exp_in", exp_key_in[255:128], 0);
    check("rst_exp_round", exp_round, 0);
    reset = 1'b0;

    // AES-128, including reads during EXPAND and around the done edge
    rd_idx = 4'd0;
    start_run(K128, 2'b00);
    check("t1_busy", busy, 1);
    check("t1_exp_round", exp_round, 1);
    tick;
    tick;
    check("t1_rd_exp_key", rd_key, 0);
    check("t1_rd_exp_err", rd_err, 1);
    wait_done(n);
    check("t1_latency", n + 2, 10);
    check("t1_kv", keys_valid, 1);
    check("t1_busy_low", busy, 0);
    check("t1_rd_at_done", rd_err, 1);
    tick;
    check("t1_done_pulse", done, 0);
    check("t1_rk0", rd_key, K128[255:128]);
    check("t1_rk0_err", rd_err, 0);
    read(4'd1);
    check("t1_rk1", rd_key, 128'ha0fafe1788542cb123a339392a6c7605);
    read(4'd10);
    check("t1_rk10", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    read(4'd11);
    check("t1_rk11_key", rd_key, 0);
    check("t1_rk11_err", rd_err, 1);

    // AES-256
    start_run(K256, 2'b10);
    wait_done(n);
    check("t2_latency", n, 14);
    read(4'd1);
    check("t2_rk1", rd_key, K256[127:0]);
    read(4'd2);
    check("t2_rk2", rd_key, 128'h9ba354118e6925afa51a8b5f2067fcde);
    read(4'd14);
    check("t2_rk14", rd_key, 128'hfe4890d1e6188d0b046df344706c631e);
    read(4'd15);
    check("t2_rk15_err", rd_err, 1);
    check("t2_rk15_key", rd_key, 0);

    // illegal alg leaves the stored schedule alone
    start_run(K128, 2'b11);
    check("t3_err", err, 1);
    check("t3_busy", busy, 0);
    check("t3_kv", keys_valid, 1);
    rd_idx = 4'd14;
    tick;
    check("t3_err_pulse", err, 0);
    check("t3_rk14", rd_key, 128'hfe4890d1e6188d0b046df344706c631e);

    // start while busy is ignored; a start right after done is taken
    start_run(K128, 2'b00);
    tick;
    tick;
    tick;
    tick;
    start_run(K256, 2'b10);
    rd_idx = 4'd10;
    wait_done(n);
    check("t4_latency", n + 5, 10);
    start_run(K192, 2'b01);
    check("t4_rk10", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("t4_rk10_err", rd_err, 0);
    check("t4_restart_busy", busy, 1);
    check("t4_restart_kv", keys_valid, 0);

    // reset in the middle of an AES-192 run
    tick;
    tick;
    tick;
    tick;
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("t5_busy", busy, 0);
    check("t5_kv", keys_valid, 0);
    done_seen = 0;
    for (int c = 0; c < 16; c++) begin
      tick;
      if (done === 1'b1) done_seen++;
    end
    check("t5_no_done", done_seen, 0);
    read(4'd0);
    check("t5_rd0_key", rd_key, 0);
    check("t5_rd0_err", rd_err, 1);
    read(4'd5);
    check("t5_rd5_err", rd_err, 1);
    start_run(K192, 2'b01);
    wait_done(n);
    check("t5_latency", n, 12);
    read(4'd12);
    check("t5_rk12", rd_key, 128'he98ba06f448c773c8ecc720401002202);
    read(4'd13);
    check("t5_rk13_err", rd_err, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
